hdmi_tx_init_sequencer: RTL and testbench

- Sequences HDMI transmitter bring-up.
- After power-up it waits a settle interval, then walks a register table and issues one I2C byte-write request per entry to the I2C write master.
- NACKs are retried a bounded number of times; READY asserts when the table completes.
- A hot-plug interrupt or a start pulse re-runs the table. Sits between the HDMI TX wrapper and the I2C master.

---
 rtl/hdmi_tx_init_sequencer_if.sv | 26 ++
 rtl/hdmi_tx_init_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_hdmi_tx_init_sequencer.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdmi_tx_init_sequencer_if.sv
// ---------------------------------------------------------------------------
// hdmi_tx_init_sequencer_if
// Byte-write request channel between the HDMI init sequencer and the I2C
// write master.
//
// Signals:
//   req   - write request, held high while a write is outstanding
//   data  - {dev_addr[23:16], reg[15:8], val[7:0]}, stable while req is high
//   ack   - one-cycle pulse: write finished and the slave ACKed
//   nack  - one-cycle pulse: write finished and the slave NACKed
//
// Handshake: the master raises req with data valid and keeps both unchanged
// until the slave returns exactly one ack or nack pulse; the write is
// complete on the clock edge that samples that pulse and req drops on the
// following cycle.  ack/nack arriving while req is low carry no meaning and
// are ignored.  If ack and nack coincide, the write counts as NACKed.
// ---------------------------------------------------------------------------
interface hdmi_tx_init_sequencer_if;
    logic        req;
    logic [23:0] data;
    logic        ack;
    logic        nack;

    modport master (output req, output data, input ack, input nack);
    modport slave  (input req, input data, output ack, output nack);
endinterface

// File: rtl/hdmi_tx_init_sequencer.sv
// ---------------------------------------------------------------------------
// hdmi_tx_init_sequencer
// Brings up an HDMI transmitter: waits a power-up settle interval, then
// walks a register table and issues one I2C byte-write per entry.  NACKed
// writes are retried after an idle gap, up to MAX_RETRY times.  A start
// pulse or a rising edge of the transmitter interrupt re-runs the table.
//
// Ports:
//   iCLK, iRST_N  - clock, asynchronous active-low reset
//   iSTART        - single-cycle re-run request
//   iTX_INT       - asynchronous interrupt / hot-plug, synchronised here
//   oTBL_IDX      - table index being addressed
//   iTBL_DATA     - {reg, val} for oTBL_IDX, combinational lookup
//   i2c           - write request channel (master side)
//   oBUSY         - sequence in progress
//   oREADY        - table completed successfully
//   oERROR        - an entry failed after all retries
//   oSTATE        - current FSM state, for observation
// ---------------------------------------------------------------------------
module hdmi_tx_init_sequencer #(
    parameter int unsigned PWRUP_CYCLES = 1000000,
    parameter int unsigned NUM_REGS     = 31,
    parameter logic [7:0]  DEV_ADDR     = 8'h72,
    parameter int unsigned MAX_RETRY    = 3,
    parameter int unsigned RETRY_GAP    = 5000
) (
    input  logic                            iCLK,
    input  logic                            iRST_N,
    input  logic                            iSTART,
    input  logic                            iTX_INT,
    output logic [5:0]                      oTBL_IDX,
    input  logic [15:0]                     iTBL_DATA,
    hdmi_tx_init_sequencer_if.master        i2c,
    output logic                            oBUSY,
    output logic                            oREADY,
    output logic                            oERROR,
    output logic [2:0]                      oSTATE
);

    typedef enum logic [2:0] {
        S_PWRUP = 3'd0,
        S_LOAD  = 3'd1,
        S_REQ   = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4,
        S_FAIL  = 3'd5
    } state_e;

    // One counter serves both the power-up settle and the retry gap.
    localparam int unsigned CNT_MAX = (PWRUP_CYCLES > RETRY_GAP) ? PWRUP_CYCLES : RETRY_GAP;
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int RW = $clog2(MAX_RETRY + 2);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [5:0]    idx_q, idx_d;
    logic [23:0]   data_q, data_d;
    logic          req_q, req_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          error_q, error_d;
    logic          pending_q, pending_d;
    logic          sync1_q, sync2_q, sync3_q;
    logic          event_w;

    // sync3_q is the edge register: one event per rising edge of the
    // synchronised interrupt, however long the interrupt stays high.
    assign event_w = iSTART | (sync2_q & ~sync3_q);

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state_q   <= S_PWRUP;
            cnt_q     <= '0;
            retry_q   <= '0;
            idx_q     <= '0;
            data_q    <= '0;
            req_q     <= 1'b0;
            busy_q    <= 1'b1;
            ready_q   <= 1'b0;
            error_q   <= 1'b0;
            pending_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            idx_q     <= idx_d;
            data_q    <= data_d;
            req_q     <= req_d;
            busy_q    <= busy_d;
            ready_q   <= ready_d;
            error_q   <= error_d;
            pending_q <= pending_d;
            sync1_q   <= iTX_INT;
            sync2_q   <= sync1_q;
            sync3_q   <= sync2_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retry_d   = retry_q;
        idx_d     = idx_q;
        data_d    = data_q;
        pending_d = pending_q;

        unique case (state_q)
            S_PWRUP: begin
                // Events are deliberately dropped while the part settles.
                if (cnt_q == CW'(PWRUP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_LOAD: begin
                data_d  = {DEV_ADDR, iTBL_DATA};
                state_d = S_REQ;
                if (event_w) pending_d = 1'b1;
            end
            S_REQ: begin
                if (i2c.nack) begin
                    if (event_w) pending_d = 1'b1;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        cnt_d   = '0;
                        state_d = S_GAP;
                    end else begin
                        state_d = S_FAIL;
                    end
                end else if (i2c.ack) begin
                    retry_d = '0;
                    // A restart request, even one arriving with this ACK,
                    // wins over advancing or finishing.
                    if (pending_q || event_w) begin
                        pending_d = 1'b0;
                        idx_d     = '0;
                        state_d   = S_LOAD;
                    end else if (idx_q == 6'(NUM_REGS - 1)) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        state_d = S_LOAD;
                    end
                end else if (event_w) begin
                    pending_d = 1'b1;
                end
            end
            S_GAP: begin
                if (event_w) pending_d = 1'b1;
                if (cnt_q == CW'(RETRY_GAP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_REQ;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE, S_FAIL: begin
                if (event_w) begin
                    idx_d     = '0;
                    retry_d   = '0;
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end
            end
            default: state_d = S_PWRUP;
        endcase

        // Status flags are registered from the next state so they change on
        // the same edge as the state itself.
        req_d   = (state_d == S_REQ);
        ready_d = (state_d == S_DONE);
        error_d = (state_d == S_FAIL);
        busy_d  = (state_d != S_DONE) && (state_d != S_FAIL);
    end

    assign i2c.req  = req_q;
    assign i2c.data = data_q;
    assign oTBL_IDX = idx_q;
    assign oBUSY    = busy_q;
    assign oREADY   = ready_q;
    assign oERROR   = error_q;
    assign oSTATE   = state_q;

endmodule

// File: tb/tb_hdmi_tx_init_sequencer.sv
// ---------------------------------------------------------------------------
// tb_hdmi_tx_init_sequencer
// Directed scenarios with randomized table contents, response delays and
// NACKed entries.  Expected write streams come from a table-walk model.
// ---------------------------------------------------------------------------
module tb_hdmi_tx_init_sequencer;

    localparam int PWRUP = 10;
    localparam int NREG  = 4;
    localparam int MAXR  = 2;
    localparam int GAP   = 5;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        tx_int = 1'b0;
    logic [5:0]  tbl_idx;
    logic [15:0] tbl_data;
    logic        busy, ready, error;
    logic [2:0]  state_dbg;
    logic [15:0] tbl [NREG];

    always #10 clk = ~clk;

    hdmi_tx_init_sequencer_if bus ();

    hdmi_tx_init_sequencer #(
        .PWRUP_CYCLES (PWRUP),
        .NUM_REGS     (NREG),
        .DEV_ADDR     (8'h72),
        .MAX_RETRY    (MAXR),
        .RETRY_GAP    (GAP)
    ) dut (
        .iCLK      (clk),
        .iRST_N    (rst_n),
        .iSTART    (start),
        .iTX_INT   (tx_int),
        .oTBL_IDX  (tbl_idx),
        .iTBL_DATA (tbl_data),
        .i2c       (bus.master),
        .oBUSY     (busy),
        .oREADY    (ready),
        .oERROR    (error),
        .oSTATE    (state_dbg)
    );

    assign tbl_data = tbl[tbl_idx[1:0]];

    // ---------------- bookkeeping ----------------
    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int rel_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- write monitor ----------------
    logic        req_prev = 1'b0;
    int          rise_cyc_q[$];
    logic [23:0] wr_data_q[$];
    logic [5:0]  wr_idx_q[$];
    int          nack_cyc_q[$];

    always @(negedge clk) begin
        if (bus.req && !req_prev) begin
            rise_cyc_q.push_back(cyc);
            wr_data_q.push_back(bus.data);
            wr_idx_q.push_back(tbl_idx);
        end
        req_prev <= bus.req;
    end

    // ---------------- I2C slave responder ----------------
    int nack_left[NREG];
    int fixed_delay = 2;
    bit rand_delay = 1'b0;
    bit rsp_seen = 1'b0;
    bit rsp_done = 1'b0;
    int rsp_cnt = 0;

    initial begin
        bus.ack  = 1'b0;
        bus.nack = 1'b0;
        forever begin
            @(negedge clk);
            bus.ack  = 1'b0;
            bus.nack = 1'b0;
            if (!bus.req) begin
                rsp_seen = 1'b0;
                rsp_done = 1'b0;
            end else if (!rsp_done) begin
                if (!rsp_seen) begin
                    rsp_seen = 1'b1;
                    rsp_cnt  = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
                end
                if (rsp_cnt == 0) begin
                    rsp_done = 1'b1;
                    if (nack_left[tbl_idx[1:0]] > 0) begin
                        nack_left[tbl_idx[1:0]]--;
                        bus.nack = 1'b1;
                        nack_cyc_q.push_back(cyc + 1);
                    end else begin
                        bus.ack = 1'b1;
                    end
                end else begin
                    rsp_cnt--;
                end
            end
        end
    end

    // ---------------- reference model ----------------
    logic [23:0] exp_data_q[$];
    logic [5:0]  exp_idx_q[$];
    int          nk[NREG];
    bit          ok;

    // Walks entries 0..last; an entry NACKed n times is written n+1 times,
    // and more than MAXR NACKs means MAXR+1 writes followed by failure.
    function automatic bit model_table(input int last);
        for (int e = 0; e <= last; e++) begin
            int tries;
            tries = (nk[e] > MAXR) ? MAXR + 1 : nk[e] + 1;
            for (int t = 0; t < tries; t++) begin
                exp_data_q.push_back({8'h72, tbl[e]});
                exp_idx_q.push_back(6'(e));
            end
            if (nk[e] > MAXR) return 1'b0;
        end
        return 1'b1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_log(input string tag);
        check({tag, "_count"}, 32'(wr_data_q.size()), 32'(exp_data_q.size()));
        for (int i = 0; i < wr_data_q.size() && i < exp_data_q.size(); i++) begin
            check($sformatf("%s_data%0d", tag, i), 32'(wr_data_q[i]), 32'(exp_data_q[i]));
            check($sformatf("%s_idx%0d", tag, i), 32'(wr_idx_q[i]), 32'(exp_idx_q[i]));
        end
    endtask

    task automatic clear_all();
        rise_cyc_q.delete();
        wr_data_q.delete();
        wr_idx_q.delete();
        nack_cyc_q.delete();
        exp_data_q.delete();
        exp_idx_q.delete();
        for (int i = 0; i < NREG; i++) begin
            nk[i] = 0;
            nack_left[i] = 0;
        end
    endtask

    task automatic new_table();
        for (int i = 0; i < NREG; i++) tbl[i] = 16'($urandom);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic pulse_tx_int();
        @(negedge clk);
        #3 tx_int = 1'b1;
        repeat (3) @(negedge clk);
        tx_int = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        for (int i = 0; i < budget && !ready; i++) @(negedge clk);
    endtask

    task automatic wait_error(input int budget);
        for (int i = 0; i < budget && !error; i++) @(negedge clk);
    endtask

    task automatic wait_writes(input int n, input int budget);
        for (int i = 0; i < budget && wr_data_q.size() < n; i++) @(negedge clk);
    endtask

    task automatic wait_req_idx(input int idx, input int budget);
        for (int i = 0; i < budget && !(bus.req && tbl_idx == 6'(idx)); i++) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int e;
        new_table();
        clear_all();
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",  32'(busy),     32'd1);
        check("rst_ready", 32'(ready),    32'd0);
        check("rst_error", 32'(error),    32'd0);
        check("rst_req",   32'(bus.req),  32'd0);
        check("rst_data",  32'(bus.data), 32'd0);
        check("rst_idx",   32'(tbl_idx),  32'd0);

        // 1: power-up, plain table walk, ACK 3 cycles after each request
        rand_delay  = 1'b0;
        fixed_delay = 2;
        ok = model_table(NREG - 1);
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_writes(NREG, 300);
        wait_ready(100);
        if (rise_cyc_q.size() > 0)
            check("s1_first_req_cycle", 32'(rise_cyc_q[0] - rel_cyc), 32'd11);
        check_log("s1");
        check("s1_ready", 32'(ready), 32'(ok));
        check("s1_busy",  32'(busy),  32'd0);
        check("s1_error", 32'(error), 32'd0);
        repeat (20) @(negedge clk);
        check("s1_no_extra", 32'(wr_data_q.size()), 32'(NREG));

        // 2: one random entry NACKed twice then ACKed
        clear_all();
        new_table();
        rand_delay = 1'b1;
        e = int'($urandom_range(0, NREG - 1));
        nk[e] = 2;
        nack_left[e] = 2;
        ok = model_table(NREG - 1);
        pulse_start();
        wait_ready(400);
        check_log("s2");
        check("s2_nacks", 32'(nack_cyc_q.size()), 32'd2);
        for (int j = 0; j < nack_cyc_q.size(); j++)
            if (rise_cyc_q.size() > e + 1 + j)
                check($sformatf("s2_gap%0d", j), 32'(rise_cyc_q[e + 1 + j] - nack_cyc_q[j]), 32'(GAP));
        check("s2_ready", 32'(ready), 32'(ok));
        check("s2_error", 32'(error), 32'd0);

        // 3: one random entry NACKed past the retry limit, then restart
        clear_all();
        new_table();
        e = int'($urandom_range(0, NREG - 1));
        nk[e] = MAXR + 1;
        nack_left[e] = MAXR + 1;
        ok = model_table(NREG - 1);
        pulse_start();
        wait_error(400);
        check("s3_error", 32'(error), 32'(!ok));
        check("s3_ready", 32'(ready), 32'd0);
        check("s3_busy",  32'(busy),  32'd0);
        repeat (30) @(negedge clk);
        check_log("s3_fail");
        clear_all();
        ok = model_table(NREG - 1);
        pulse_start();
        check("s3_error_clr", 32'(error), 32'd0);
        check("s3_busy_set",  32'(busy),  32'd1);
        wait_ready(400);
        check_log("s3_rerun");
        check("s3_ready", 32'(ready), 32'(ok));

        // 4: interrupt in DONE gives exactly one rerun
        clear_all();
        new_table();
        ok = model_table(NREG - 1);
        pulse_tx_int();
        wait_writes(1, 100);
        check("s4_ready_low", 32'(ready), 32'd0);
        check("s4_busy_high", 32'(busy),  32'd1);
        wait_ready(400);
        repeat (30) @(negedge clk);
        check_log("s4");
        check("s4_ready", 32'(ready), 32'(ok));

        // 5: interrupt while entry 2 is outstanding restarts after its ACK
        clear_all();
        new_table();
        rand_delay  = 1'b0;
        fixed_delay = 8;
        ok = model_table(2);
        ok = model_table(NREG - 1);
        pulse_start();
        wait_req_idx(2, 300);
        check("s5_at_idx2", 32'(bus.req && tbl_idx == 6'd2), 32'd1);
        pulse_tx_int();
        wait_ready(600);
        repeat (20) @(negedge clk);
        check_log("s5");
        check("s5_ready", 32'(ready), 32'(ok));

        // 6: reset while a request is outstanding
        clear_all();
        pulse_start();
        wait_writes(1, 100);
        check("s6_req_before", 32'(bus.req), 32'd1);
        #3 rst_n = 1'b0;
        #1;
        check("s6_req_async", 32'(bus.req), 32'd0);
        check("s6_busy_rst",  32'(busy),    32'd1);
        check("s6_idx_rst",   32'(tbl_idx), 32'd0);
        @(negedge clk);
        clear_all();
        new_table();
        rand_delay = 1'b1;
        ok = model_table(NREG - 1);
        @(negedge clk);
        rst_n = 1'b1;
        rel_cyc = cyc;
        wait_writes(1, 100);
        if (rise_cyc_q.size() > 0)
            check("s6_first_req_cycle", 32'(rise_cyc_q[0] - rel_cyc), 32'd11);
        wait_ready(400);
        check_log("s6");
        check("s6_ready", 32'(ready), 32'(ok));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
